div_ce_ctrl: RTL
================

Name: div_ce_ctrl

Overview:
- Single-clock controller that sequences a programmable clock-enable divider.
- Accepts a divide ratio over a valid/ready config handshake, runs or stops on command, and issues one-cycle `ce` strobes plus a wrapping period counter `po_cnt`.
- Drains the in-flight period cleanly on stop.
- Used instead of derived clocks: downstream logic stays on `clk` and qualifies with `ce`.

Parameters:
- DIV_W, 8, width of the divide-ratio field.
- DEF_DIV, 4, divide ratio loaded at reset.
- CNT_W, 2, width of `po_cnt`.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  config request
- cfg_div  in  DIV_W  requested divide ratio N
- cfg_ready  out  1  config accepted when high with `cfg_valid`
- start  in  1  begin run, single-cycle command
- stop  in  1  end run after current period, single-cycle command
- busy  out  1  state != IDLE
- ce  out  1  one-cycle enable strobe, once per N cycles
- po_cnt  out  CNT_W  count of issued `ce` strobes, modulo 2^CNT_W

Behaviour:
- Reset: all of the following hold while `rst` is high; reset mid-run aborts immediately with no final `ce`.
  - state=IDLE, div_reg=DEF_DIV, div_cnt=0
  - ce=0, po_cnt=0, busy=0, cfg_ready=1
- States: IDLE(0), RUN(1), DRAIN(2); 2-bit encoding; value 3 returns to IDLE.
- Config handshake:
  - `cfg_ready` is combinational, equal to (state==IDLE).
  - On an edge with cfg_valid&cfg_ready: div_reg <= cfg_div, with 0 mapped to 1.
  - `cfg_valid` outside IDLE is not accepted; the requester holds it.
- IDLE:
  - div_cnt=0, ce=0, po_cnt holds.
  - start -> RUN.
  - If cfg is accepted on the same edge as start, the new ratio applies to that run.
  - stop is ignored.
- RUN:
  - div_cnt counts 0..N-1, then wraps to 0 (N=div_reg).
  - On the edge where div_cnt==N-1: ce<=1 for one cycle and po_cnt<=po_cnt+1 (wraps 2^CNT_W-1 -> 0).
  - First `ce` is visible N cycles after the edge that sampled start; then every N cycles.
  - N=1: ce is high every cycle.
  - start is ignored.
- stop in RUN:
  - If div_cnt==N-1 on that edge: final ce and po_cnt increment, then -> IDLE.
  - Otherwise -> DRAIN.
  - Simultaneous start and stop: stop wins.
- DRAIN:
  - Counting continues; the wrap edge issues the final ce and po_cnt increment, then -> IDLE, div_cnt=0.
  - start and stop are ignored.
- `ce`, `po_cnt` and `busy` are registered; `busy` falls in the same cycle the final `ce` is high.
- Latency:
  - start-to-busy: 1 cycle.
  - stop-to-idle: at most N cycles.

Optional Feature:
- Macro: DIV_SQ_OUT_EN.
- Defined:
  - Adds output port `clk_sq` (1 bit, registered, used as data only, never as a clock).
  - Each period: low for ceil(N/2) cycles, then high for floor(N/2) cycles.
  - Falls on the same edge that raises `ce`.
  - Held 0 in IDLE, at reset, and for N=1.
  - N=4 gives a 2-low/2-high pattern.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then start with DEF_DIV=4 -> busy=1 next cycle; ce pulses at cycles 4, 8, 12, 16 after start; po_cnt goes 1, 2, 3, 0.
- In IDLE, cfg_valid=1, cfg_div=3, cfg_ready=1; start on the same cycle -> ce every 3 cycles from cycle 3.
- In RUN with N=4, cfg_valid=1, cfg_div=7 -> cfg_ready=0, ratio unchanged; accepted in the first IDLE cycle after stop.
- N=5, stop when div_cnt=1 -> DRAIN, exactly one more ce 3 cycles later, busy falls with it, po_cnt +1; stop when div_cnt=4 -> straight to IDLE with final ce.
- cfg_div=0 then start -> ce high every cycle (N=1); start+stop in the same RUN cycle -> stop wins.
- rst asserted in DRAIN -> next cycle state=IDLE, ce=0, po_cnt=0, div_reg=4; with DIV_SQ_OUT_EN, N=4 -> clk_sq pattern 0,0,1,1 aligned with ce.

Source files
------------

// File: rtl/div_ce_ctrl.sv
// div_ce_ctrl
//   Sequences a programmable clock-enable divider. A divide ratio N is loaded
//   over a valid/ready handshake while idle. Once started, the block issues a
//   one-cycle `ce` strobe every N cycles and counts strobes in `po_cnt`. On
//   stop, the in-flight period is allowed to finish, so the last period is
//   always a full N cycles. Downstream logic stays on `clk` and qualifies its
//   work with `ce` instead of using a derived clock.
//
// Parameters
//   DIV_W   width of the divide-ratio field
//   DEF_DIV divide ratio loaded at reset
//   CNT_W   width of the strobe counter po_cnt
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   cfg_valid  config request
//   cfg_div    requested divide ratio (0 is treated as 1)
//   cfg_ready  config accepted when high together with cfg_valid (idle only)
//   start      begin run (single-cycle command)
//   stop       end run after the current period (single-cycle command)
//   busy       high whenever the controller is not idle
//   ce         one-cycle enable strobe, once per N cycles
//   po_cnt     number of issued ce strobes, modulo 2^CNT_W
//   clk_sq     (only with DIV_SQ_OUT_EN) registered square wave, data only:
//              low for ceil(N/2) cycles, then high for floor(N/2) cycles
//
// Optional feature macro: DIV_SQ_OUT_EN
module div_ce_ctrl #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 4,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             ce,
  output logic [CNT_W-1:0] po_cnt
`ifdef DIV_SQ_OUT_EN
  ,
  output logic             clk_sq
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] div_cnt, cnt_next;
  logic             ce_next;
  logic [CNT_W-1:0] po_next;
  logic             wrap;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Last cycle of the current period; div_reg is never 0, so N-1 is safe.
  assign wrap = (div_cnt == div_reg - 1'b1);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    div_next   = div_reg;
    cnt_next   = div_cnt;
    ce_next    = 1'b0;
    po_next    = po_cnt;

    if (cfg_valid && cfg_ready) begin
      div_next = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    end

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (start) state_next = RUN;
      end
      RUN: begin
        cnt_next = wrap ? '0 : div_cnt + 1'b1;
        if (wrap) begin
          ce_next = 1'b1;
          po_next = po_cnt + 1'b1;
        end
        // stop has priority over a simultaneous start (start is ignored here)
        if (stop) state_next = wrap ? IDLE : DRAIN;
      end
      DRAIN: begin
        cnt_next = wrap ? '0 : div_cnt + 1'b1;
        if (wrap) begin
          ce_next    = 1'b1;
          po_next    = po_cnt + 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        // Unused encoding 3 recovers to IDLE.
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_reg <= DIV_W'(DEF_DIV);
      div_cnt <= '0;
      ce      <= 1'b0;
      po_cnt  <= '0;
    end else begin
      state   <= state_next;
      div_reg <= div_next;
      div_cnt <= cnt_next;
      ce      <= ce_next;
      po_cnt  <= po_next;
    end
  end

`ifdef DIV_SQ_OUT_EN
  // ceil(N/2): the count value at which the square wave goes high. One extra
  // bit avoids overflow when N is at its maximum.
  logic [DIV_W:0] half_n;
  assign half_n = ({1'b0, div_reg} + 1'b1) >> 1;

  // Registered from the next count value, so it falls on the same edge that
  // raises ce (count returns to 0) and is 0 whenever the next state is IDLE.
  // For N=1 the next count is always 0, which is below ceil(1/2)=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sq <= 1'b0;
    end else begin
      clk_sq <= (state_next != IDLE) && ({1'b0, cnt_next} >= half_n);
    end
  end
`endif

endmodule
